// File: rtl/receiver.sv
// receiver: GMII receive engine.
//   Captures frames on gmii_rx_clk, timestamps them with global_counter at the
//   SFD, and writes them into the RX frame-slot ring (16-bit words, 14-bit
//   word address). A frame is published by advancing mem_wr_ptr. Runt,
//   errored and overflowing frames, and optionally FCS-bad frames, are
//   dropped and counted instead.
//
//   Slot layout at mem_wr_ptr:
//     word 0     frame length in bytes (FCS excluded)
//     words 1-4  timestamp [63:48] .. [15:0]
//     words 5-6  received FCS [31:16], [15:0] (wire order, big-endian)
//     words 7+   data, even byte in [15:8], odd byte in [7:0]
//
// Ports:
//   gmii_rx_clk          sole clock
//   sys_rst_n            asynchronous active-low reset
//   global_counter[63:0] free-running timestamp source
//   gmii_rxd[7:0]        receive data
//   gmii_rx_dv           receive data valid
//   gmii_rx_er           receive error
//   slot_rx_eth_data     ring write data
//   slot_rx_eth_byte_en  ring byte enables (bit1 -> [15:8], bit0 -> [7:0])
//   slot_rx_eth_addr     ring write word address
//   slot_rx_eth_wr_en    ring write strobe, one word per cycle
//   mem_rd_ptr           consumer read pointer (words)
//   mem_wr_ptr           committed write pointer (words)
//   rx_drop_count        dropped-frame count, saturating at 0xFFFF
//
// Build option:
//   RX_FCS_CHECK_EN  when defined, a CRC-32 is computed over every byte after
//                    the SFD (FCS included) and frames whose residue is not
//                    0xC704DD7B are dropped. When undefined no CRC logic is
//                    built and the FCS is only stored in the header.
module receiver #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned HDR_WORDS     = 7
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] global_counter,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [15:0] slot_rx_eth_data,
  output logic [1:0]  slot_rx_eth_byte_en,
  output logic [13:0] slot_rx_eth_addr,
  output logic        slot_rx_eth_wr_en,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] mem_wr_ptr,
  output logic [15:0] rx_drop_count
);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA,
    RX_HDR,
    RX_DROP
  } state_e;

  state_e      state_q;
  logic [63:0] ts_q;
  logic [15:0] cnt_q;
  logic [31:0] fcs_q;
  logic [15:0] len_q;
  logic [2:0]  hdr_idx_q;

  logic [13:0] free_words;
  logic [16:0] data_off;
  logic        data_ovf;
  logic        byte_take;
  logic        sfd_seen;
  logic [15:0] frame_len;
  logic        frame_runt;
  logic        fcs_ok;
  logic [15:0] commit_adv;
  logic [15:0] drop_inc;
  logic [15:0] hdr_word;

  always_comb begin
    free_words = mem_rd_ptr - mem_wr_ptr - 14'd1;
    // Offset is kept wider than the ring so a long frame cannot alias back
    // below the free-space limit.
    data_off   = 17'(HDR_WORDS) + {2'b00, cnt_q[15:1]};
    data_ovf   = data_off >= {3'b000, free_words};
    byte_take  = (state_q == RX_DATA) && gmii_rx_dv && !gmii_rx_er && !data_ovf;
    sfd_seen   = (state_q == RX_PREAMBLE) && gmii_rx_dv && (gmii_rxd == 8'hD5);
    frame_len  = cnt_q - 16'd4;
    frame_runt = cnt_q < 16'(MIN_FRAME_LEN);
    // Slot size: header plus ceil(len/2) data words.
    commit_adv = 16'(HDR_WORDS) + {1'b0, len_q[15:1]} + {15'd0, len_q[0]};
    drop_inc   = (rx_drop_count == '1) ? rx_drop_count : rx_drop_count + 16'd1;
  end

  always_comb begin
    hdr_word = '0;
    case (hdr_idx_q)
      3'd1:    hdr_word = ts_q[63:48];
      3'd2:    hdr_word = ts_q[47:32];
      3'd3:    hdr_word = ts_q[31:16];
      3'd4:    hdr_word = ts_q[15:0];
      3'd5:    hdr_word = fcs_q[31:16];
      3'd6:    hdr_word = fcs_q[15:0];
      default: hdr_word = '0;
    endcase
  end

`ifdef RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc_q;

  // Reflected (LSB-first) CRC-32, one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crc_q <= '1;
    end else if (sfd_seen) begin
      crc_q <= '1;
    end else if (byte_take) begin
      crc_q <= crc32_byte(crc_q, gmii_rxd);
    end
  end

  // The register runs bit-reflected, so the residue is compared in normal order.
  assign fcs_ok = (bitrev32(crc_q) == CRC_RESIDUE);
`else
  assign fcs_ok = 1'b1;
`endif

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q             <= RX_IDLE;
      ts_q                <= '0;
      cnt_q               <= '0;
      fcs_q               <= '0;
      len_q               <= '0;
      hdr_idx_q           <= '0;
      slot_rx_eth_data    <= '0;
      slot_rx_eth_byte_en <= '0;
      slot_rx_eth_addr    <= '0;
      slot_rx_eth_wr_en   <= 1'b0;
      mem_wr_ptr          <= '0;
      rx_drop_count       <= '0;
    end else begin
      slot_rx_eth_wr_en <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (gmii_rx_dv && (gmii_rxd == 8'h55)) state_q <= RX_PREAMBLE;
        end

        RX_PREAMBLE: begin
          if (sfd_seen) begin
            ts_q    <= global_counter;
            cnt_q   <= '0;
            fcs_q   <= '0;
            state_q <= RX_DATA;
          end else if (!gmii_rx_dv || (gmii_rxd != 8'h55)) begin
            state_q <= RX_IDLE;
          end
        end

        RX_DATA: begin
          if (gmii_rx_dv) begin
            if (byte_take) begin
              slot_rx_eth_wr_en <= 1'b1;
              slot_rx_eth_addr  <= mem_wr_ptr + data_off[13:0];
              if (!cnt_q[0]) begin
                slot_rx_eth_byte_en <= 2'b10;
                slot_rx_eth_data    <= {gmii_rxd, 8'h00};
              end else begin
                slot_rx_eth_byte_en <= 2'b01;
                slot_rx_eth_data    <= {8'h00, gmii_rxd};
              end
              cnt_q <= cnt_q + 16'd1;
              fcs_q <= {fcs_q[23:0], gmii_rxd};
            end else begin
              rx_drop_count <= drop_inc;
              state_q       <= RX_DROP;
            end
          end else if (frame_runt || !fcs_ok) begin
            rx_drop_count <= drop_inc;
            state_q       <= RX_IDLE;
          end else begin
            // Header word 0 goes out on the frame-end edge so the seven
            // header writes fill the seven cycles right after dv falls.
            slot_rx_eth_wr_en   <= 1'b1;
            slot_rx_eth_addr    <= mem_wr_ptr;
            slot_rx_eth_byte_en <= 2'b11;
            slot_rx_eth_data    <= frame_len;
            len_q               <= frame_len;
            hdr_idx_q           <= 3'd1;
            state_q             <= RX_HDR;
          end
        end

        RX_HDR: begin
          if (hdr_idx_q == 3'(HDR_WORDS)) begin
            mem_wr_ptr <= mem_wr_ptr + commit_adv[13:0];
            state_q    <= RX_IDLE;
          end else begin
            slot_rx_eth_wr_en   <= 1'b1;
            slot_rx_eth_addr    <= mem_wr_ptr + {11'd0, hdr_idx_q};
            slot_rx_eth_byte_en <= 2'b11;
            slot_rx_eth_data    <= hdr_word;
            hdr_idx_q           <= hdr_idx_q + 3'd1;
          end
        end

        RX_DROP: begin
          if (!gmii_rx_dv) state_q <= RX_IDLE;
        end

        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;

`ifdef RX_FCS_CHECK_EN
  localparam bit FCS_CHK = 1'b1;
`else
  localparam bit FCS_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] gc_base;
  int unsigned cyc = 0;
  logic [63:0] global_counter;
  logic [7:0]  rxd;
  logic        dv, er;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic [13:0] waddr;
  logic        wen;
  logic [13:0] rd_ptr, wr_ptr;
  logic [15:0] drops;

  receiver #(.MIN_FRAME_LEN(64)) dut (
    .gmii_rx_clk        (clk),
    .sys_rst_n          (rst_n),
    .global_counter     (global_counter),
    .gmii_rxd           (rxd),
    .gmii_rx_dv         (dv),
    .gmii_rx_er         (er),
    .slot_rx_eth_data   (wdata),
    .slot_rx_eth_byte_en(wbe),
    .slot_rx_eth_addr   (waddr),
    .slot_rx_eth_wr_en  (wen),
    .mem_rd_ptr         (rd_ptr),
    .mem_wr_ptr         (wr_ptr),
    .rx_drop_count      (drops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign global_counter = gc_base + 64'(cyc);

  typedef struct {
    int unsigned c;
    logic [13:0] a;
    logic [1:0]  be;
    logic [15:0] d;
  } wr_t;

  wr_t         wq[$];
  wr_t         eq[$];
  logic [13:0] wp_seen = '0;
  int unsigned wp_chg = 0;

  always @(negedge clk) begin
    if (wen === 1'b1) wq.push_back('{c: cyc, a: waddr, be: wbe, d: wdata});
    if (wr_ptr !== wp_seen) begin
      wp_seen = wr_ptr;
      wp_chg  = cyc;
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [13:0] wp_m;
  logic [15:0] drop_m;
  logic [7:0]  fb[$];
  int unsigned bcyc[$];
  logic [63:0] ts_exp;
  int unsigned dlow;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [7:0] d);
    @(posedge clk);
    #1;
    dv  = v;
    er  = e;
    rxd = d;
  endtask

  // Ethernet FCS value (IEEE 802.3 CRC-32) of fb[0..n-1].
  function automatic logic [31:0] crc_of(input int unsigned n);
    logic [31:0] c;
    c = '1;
    for (int unsigned i = 0; i < n; i++) begin
      c ^= {24'h0, fb[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_match();
    int unsigned n;
    n = fb.size();
    return {fb[n-1], fb[n-2], fb[n-3], fb[n-4]} == crc_of(n - 4);
  endfunction

  // Random payload of dlen bytes followed by its FCS (LSB byte first on wire).
  task automatic build(input int unsigned dlen, input bit bad, input bit mask);
    logic [31:0] f;
    fb.delete();
    for (int unsigned i = 0; i < dlen; i++) fb.push_back(8'($urandom));
    f = crc_of(dlen);
    fb.push_back(f[7:0]);
    fb.push_back(f[15:8]);
    fb.push_back(f[23:16]);
    fb.push_back(f[31:24]);
    if (bad) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
    if (mask) foreach (fb[i]) fb[i] = fb[i] & 8'hF0;
  endtask

  task automatic send_check(input string tag, input int er_at);
    int unsigned n_tot, k, mism, first;
    logic [13:0] freew;
    logic [15:0] len;
    logic [15:0] hw[7];
    bit          drop;
    wq.delete();
    eq.delete();
    bcyc.delete();
    n_tot = fb.size();
    repeat ($urandom_range(1, 7)) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    ts_exp = gc_base + 64'(cyc);
    for (int i = 0; i < int'(n_tot); i++) begin
      drive(1'b1, (i == er_at), fb[i]);
      bcyc.push_back(cyc);
    end
    drive(1'b0, 1'b0, 8'h00);
    dlow = cyc;
    repeat (12) drive(1'b0, 1'b0, 8'h00);

    // Reference: each byte n lands at word 7+n/2 one cycle after it is
    // presented, unless the ring lacks space or the byte carries an error.
    freew = rd_ptr - wp_m - 14'd1;
    drop  = 1'b0;
    for (int i = 0; i < int'(n_tot); i++) begin
      k = 7 + i / 2;
      if (i == er_at || k >= int'(freew)) begin
        drop = 1'b1;
        break;
      end
      eq.push_back('{c: bcyc[i] + 1, a: wp_m + 14'(k),
                     be: (i % 2 == 0) ? 2'b10 : 2'b01,
                     d: (i % 2 == 0) ? {fb[i], 8'h00} : {8'h00, fb[i]}});
    end
    len = 16'(n_tot - 4);
    if (!drop && (n_tot < 64 || (FCS_CHK && !fcs_match()))) drop = 1'b1;
    if (!drop) begin
      hw[0] = len;
      hw[1] = ts_exp[63:48];
      hw[2] = ts_exp[47:32];
      hw[3] = ts_exp[31:16];
      hw[4] = ts_exp[15:0];
      hw[5] = {fb[n_tot-4], fb[n_tot-3]};
      hw[6] = {fb[n_tot-2], fb[n_tot-1]};
      for (int j = 0; j < 7; j++)
        eq.push_back('{c: dlow + 1 + j, a: wp_m + 14'(j), be: 2'b11, d: hw[j]});
    end

    check({tag, ":nwrites"}, 64'(wq.size()), 64'(eq.size()));
    mism  = 0;
    first = 0;
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      if (wq[i] != eq[i]) begin
        if (mism == 0) first = i;
        mism++;
      end
    end
    check({tag, ":write_mismatches"}, 64'(mism), 64'd0);
    if (mism != 0)
      $display("  %s first differing write #%0d: got cyc=%0d a=%h be=%b d=%h, want cyc=%0d a=%h be=%b d=%h",
               tag, first, wq[first].c, wq[first].a, wq[first].be, wq[first].d,
               eq[first].c, eq[first].a, eq[first].be, eq[first].d);

    if (drop) drop_m = (drop_m == 16'hFFFF) ? drop_m : drop_m + 16'd1;
    else      wp_m   = wp_m + 14'(7 + (int'(len) + 1) / 2);
    check({tag, ":wr_ptr"}, 64'(wr_ptr), 64'(wp_m));
    check({tag, ":drop_count"}, 64'(drops), 64'(drop_m));
    if (!drop) check({tag, ":commit_cycle"}, 64'(wp_chg), 64'(dlow + 8));
  endtask

  initial begin
    logic [13:0] diff;
    int unsigned d, a;
    rst_n   = 1'b0;
    dv      = 1'b0;
    er      = 1'b0;
    rxd     = 8'h00;
    rd_ptr  = '0;
    gc_base = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check("reset:outputs", {31'd0, wdata, wbe, waddr, wen}, 64'd0);
    check("reset:ptr_drops", {34'd0, wr_ptr, drops}, 64'd0);
    rst_n  = 1'b1;
    wp_m   = '0;
    drop_m = '0;

    rd_ptr = 14'h100;
    build(60, 1'b0, 1'b0);
    send_check("good60", -1);
    check("good60:ptr37", 64'(wr_ptr), 64'd37);

    rd_ptr = wp_m + 14'h100;
    build(61, 1'b0, 1'b0);
    send_check("good61", -1);

    rd_ptr = wp_m + 14'h100;
    build(60, 1'b1, 1'b0);
    send_check("bad_fcs", -1);

    rd_ptr = wp_m + 14'd20;
    build(60, 1'b0, 1'b0);
    send_check("overflow", -1);

    rd_ptr = wp_m + 14'h100;
    build(60, 1'b0, 1'b0);
    send_check("rx_er", 20);

    for (int r = 0; r < 3; r++) begin
      rd_ptr = wp_m + 14'h400;
      build($urandom_range(60, 300), 1'b0, 1'b0);
      send_check("random", -1);
    end

    // Advance the ring to 0x3FF0 with large frames, consumer kept caught up.
    while (wp_m != 14'h3FF0) begin
      rd_ptr = wp_m;
      diff   = 14'h3FF0 - wp_m;
      d      = int'(diff);
      a      = (d > 8037) ? 8000 : d;
      build(2 * (a - 7), 1'b0, 1'b0);
      send_check("fill", -1);
    end

    rd_ptr = 14'h00F0;
    build(60, 1'b0, 1'b0);
    send_check("wrap", -1);
    check("wrap:ptr15", 64'(wr_ptr), 64'h15);

    rd_ptr = wp_m + 14'h100;
    build(36, 1'b0, 1'b0);
    send_check("runt", -1);

    // Reset in the middle of a frame; remaining bytes never contain 0x55.
    build(50, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, fb[i]);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid:outputs", {31'd0, wdata, wbe, waddr, wen}, 64'd0);
    check("rst_mid:ptr_drops", {34'd0, wr_ptr, drops}, 64'd0);
    for (int i = 20; i < 50; i++) begin
      drive(1'b1, 1'b0, fb[i]);
      if (i == 23) begin
        rst_n = 1'b1;
        wq.delete();
      end
    end
    repeat (10) drive(1'b0, 1'b0, 8'h00);
    check("rst_mid:no_writes", 64'(wq.size()), 64'd0);
    wp_m   = '0;
    drop_m = '0;
    rd_ptr = 14'h100;
    build(60, 1'b0, 1'b0);
    send_check("after_rst", -1);
    check("after_rst:ptr37", 64'(wr_ptr), 64'd37);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

GMII receive engine: the ingress counterpart of the TX sender. It captures frames from the PHY on `gmii_rx_clk` and stamps each with the 64-bit `global_counter` value at SFD. It writes each frame into the RX frame-slot ring (16-bit words, 14-bit word address) in the same slot layout the TX path consumes, then publishes it by advancing `mem_wr_ptr`. Frames that are runt, errored, overflowing or (optionally) FCS-bad are discarded without moving `mem_wr_ptr`.

## Interface
Parameters:
- `MIN_FRAME_LEN`, 64, minimum frame size in bytes after SFD including FCS; shorter frames are dropped.
- `HDR_WORDS`, 7, header words per slot; fixed, not to be overridden.

Ports:
- `gmii_rx_clk` in 1: sole clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `global_counter` in 64: free-running timestamp source.
- `gmii_rxd` in 8: receive data.
- `gmii_rx_dv` in 1: receive data valid.
- `gmii_rx_er` in 1: receive error.
- `slot_rx_eth_data` out 16: write data.
- `slot_rx_eth_byte_en` out 2: byte enables; bit 1 enables [15:8], bit 0 enables [7:0].
- `slot_rx_eth_addr` out 14: write word address.
- `slot_rx_eth_wr_en` out 1: write strobe, one word per cycle.
- `mem_rd_ptr` in 14: consumer read pointer, in words.
- `mem_wr_ptr` out 14: committed write pointer, in words.
- `rx_drop_count` out 16: count of dropped frames; saturates at 0xFFFF.

## Operation
- Slot layout, starting at `mem_wr_ptr`:
  - word 0: frame length in bytes, excluding the 4 FCS bytes.
  - words 1–4: timestamp [63:48], [47:32], [31:16], [15:0].
  - words 5–6: received FCS [31:16], [15:0], big-endian as it appeared on the wire.
  - words 7 onward: data. Even byte goes to [15:8], odd byte to [7:0].
- Ring addressing: all address arithmetic is mod 2^14. Free words = `mem_rd_ptr - mem_wr_ptr - 1` mod 2^14. Every write at offset k from `mem_wr_ptr` requires k < free words; otherwise the frame is dropped for overflow.
- States:
  - `RX_IDLE`: wait for `gmii_rx_dv` with `gmii_rxd == 0x55`, then go to `RX_PREAMBLE`.
  - `RX_PREAMBLE`: 0x55 stays in this state. 0xD5 latches `global_counter`, clears the byte count and CRC, and goes to `RX_DATA`. Any other byte, or loss of `dv`, returns to `RX_IDLE` with no drop counted.
  - `RX_DATA`: each valid byte is written immediately at word offset 7 + n/2.
    - Even n: byte_en 2'b10, data {byte, 8'h00}.
    - Odd n: byte_en 2'b01, data {8'h00, byte}.
    - The byte count increments (16-bit) and the last 4 bytes are shifted into the FCS register.
    - `gmii_rx_er` while `dv` is high, or an overflow, goes to `RX_DROP`.
    - Falling `dv` ends the frame. Total < `MIN_FRAME_LEN`, or FCS failure (see Configuration), counts a drop and returns to `RX_IDLE`. Otherwise go to `RX_HDR`.
  - `RX_HDR`: writes words 0–6 over 7 consecutive cycles with byte_en 2'b11. On the following cycle, `mem_wr_ptr <= mem_wr_ptr + 7 + ceil(len/2)`, where len = total − 4. Then go to `RX_IDLE`. GMII input is ignored in this state; the minimum IFG guarantees a new frame is still in its preamble when the state exits.
  - `RX_DROP`: counts one drop on entry. Stays until `dv` is low, then goes to `RX_IDLE`.
- FCS bytes are physically written past the data area. They lie beyond the committed pointer and are harmless.
- Dropped frames may leave stale data past `mem_wr_ptr`; `mem_wr_ptr` never moves for them.

## Timing
- Reset values (asynchronous, on `sys_rst_n` low): all outputs 0, state `RX_IDLE`, `mem_wr_ptr` = 0, `rx_drop_count` = 0.
- Reset mid-frame: the partial frame is discarded. After release, the receiver waits for the next preamble; bytes of an in-progress frame are not 0x55/0xD5 aligned and are ignored.
- Timestamp: the `global_counter` value on the cycle the SFD byte is sampled.
- Data write latency: registered, so the write for a byte sampled on cycle t is issued on cycle t+1.
- Header writes occupy the 7 cycles after the cycle where `dv` is seen low. `mem_wr_ptr` updates on cycle 8 after that. Header writes never precede the final data write.
- `mem_rd_ptr` is sampled every write cycle. The consumer only advances `mem_rd_ptr`, so free space can only grow during a frame.

## Configuration
- `RX_FCS_CHECK_EN` defined: a CRC-32 (IEEE 802.3) is computed over all bytes after SFD, FCS included. A residue other than 0xC704DD7B counts a drop and no commit is made.
- `RX_FCS_CHECK_EN` undefined: no CRC logic is built. Every frame that is error-free, non-runt and non-overflowing is committed; words 5–6 still carry the received FCS.

## Test plan
- Good frame, 60 data + 4 FCS, `mem_wr_ptr` = 0, `mem_rd_ptr` = 0x100 -> word0 = 60, timestamp matches `global_counter` at SFD, data in words 7–36, `mem_wr_ptr` = 37.
- Good frame, 61 data + 4 FCS -> last word has byte_en 2'b10 for its data byte, `mem_wr_ptr` advances by 38.
- Corrupted FCS, macro defined -> `mem_wr_ptr` unchanged, `rx_drop_count` = 1. Macro undefined -> committed, advances by 37.
- `mem_rd_ptr` = `mem_wr_ptr` + 20, 64-byte frame -> overflow drop, `mem_wr_ptr` unchanged, count increments. `gmii_rx_er` pulse mid-frame -> same drop behaviour.
- `mem_wr_ptr` = 0x3FF0, 60-byte frame -> addresses wrap through 0x0000, `mem_wr_ptr` = 0x0015. 40-byte runt -> dropped.
- `sys_rst_n` low mid-frame -> all outputs 0 immediately. The next frame after release is received correctly at slot 0.
